axis_to_fifo: RTL
=================

// Module: axis_to_fifo
// PURPOSE
//  Packer on the write side of the pcap-replay FIFO path: takes one AXI4-Stream slave, writes packed words into a FIFO write port.
//  Output format is what the FIFO-to-AXIS unpacker on the read side expects:
//   - one header word (TUSER),
//   - then data words with per-byte strobe interleaved.
//  A packet ends on the first word whose strobe is not all-ones.
//  Single clock domain (axi_aclk). The FIFO itself is external.
// PARAMETERS
//  C_S_AXIS_DATA_WIDTH   256  TDATA width in bits; multiple of 8; must be >= C_S_AXIS_TUSER_WIDTH
//  C_S_AXIS_TUSER_WIDTH  128  TUSER width in bits
//  FIFO_DATA_WIDTH       C_S_AXIS_DATA_WIDTH*9/8 (localparam)  packed FIFO word width
// PORTS
//  axi_aclk          in   1    clock
//  axi_aresetn       in   1    asynchronous active-low reset
//  sw_rst            in   1    synchronous soft reset, active-high; same effect as reset
//  s_axis_tdata      in   DW   stream data
//  s_axis_tstrb      in   DW/8 byte strobes
//  s_axis_tuser      in   UW   sideband; sampled on the first beat of each packet
//  s_axis_tvalid     in   1    beat valid
//  s_axis_tready     out  1    beat accepted when tvalid&tready
//  s_axis_tlast      in   1    last beat of packet
//  fifo_wr_en        out  1    write strobe
//  fifo_din          out  FW   packed word
//  fifo_full         in   1    FIFO full; no write may be issued while high
//  pkt_count         out  32   packets fully written (terminator included); wraps at 2^32
//  err_count         out  16   malformed beats; saturates at 16'hFFFF
// BEHAVIOUR
//  Packing: byte i of a word goes to fifo_din[9i+7:9i]; strobe i goes to fifo_din[9i+8].
//  Header word: data = {zeros, tuser}; all strobes = 1.
//  FSM states: WR_HDR (reset state), WR_PKT, WR_TERM.
//   - WR_HDR: s_axis_tready=0. If tvalid & !fifo_full: fifo_wr_en=1, write the header from the current s_axis_tuser, go to WR_PKT. The beat itself is not consumed.
//   - WR_PKT: s_axis_tready = !fifo_full. On each accepted beat, fifo_wr_en=1 and the packed beat is written.
//       - tlast & strb != all-ones: go to WR_HDR.
//       - tlast & strb == all-ones: go to WR_TERM.
//       - !tlast & strb != all-ones: malformed. err_count+1; write with strobes forced to all-ones so the reader does not end the packet early.
//   - WR_TERM: s_axis_tready=0. When !fifo_full: write terminator word (data 0, strobes 0), go to WR_HDR.
//  pkt_count increments on the word that ends the packet (non-full-strobe tlast beat, or terminator).
//  tlast with strb==0 is legal; it is written as-is and ends the packet.
//  fifo_wr_en, s_axis_tready and fifo_din are combinational from state, inputs and fifo_full. Zero latency: a word is written in the same cycle its beat is accepted.
//  While axi_aresetn=0 or sw_rst=1: fifo_wr_en=0 and s_axis_tready=0, regardless of state.
//  Reset values: state=WR_HDR, pkt_count=0, err_count=0.
//  Reset mid-packet: the partial packet is abandoned and no terminator is written. The FIFO shares the reset, so it is flushed too.
//  fifo_full rising mid-packet: stall with no write and no beat accepted; resume on the next cycle in which fifo_full is low. Data is not reordered and beats are not dropped.
//  Back-to-back packets: a header is always written between packets. Max throughput is (N+1) words per N-beat packet, plus 1 if a terminator is needed.
// TESTING
//  T1: one 3-beat packet, tuser=0x1234, strobes FF..FF, FF..FF, 0000_FFFF; fifo_full=0 -> 4 writes: header, 2 full, last with strobe 0x0000FFFF; pkt_count=1.
//  T2: 2-beat packet, last beat strobe all-ones -> writes: header, 2 data, terminator (din=0); s_axis_tready=0 on the terminator cycle; pkt_count=1.
//  T3: fifo_full high for 5 cycles after the header of a 4-beat packet -> no fifo_wr_en, s_axis_tready=0 during those cycles; all 4 beats written in order afterwards.
//  T4: middle beat with strb=0x00FF and tlast=0 -> written with all-ones strobes; err_count=1; packet still ends at tlast.
//  T5: axi_aresetn pulsed low after beat 2 of a 5-beat packet -> outputs 0 immediately (async); after release, the next tvalid produces a header write; counters=0.
//  T6: 100 back-to-back random packets (1-8 beats) with random fifo_full -> a reference unpacker model recovers identical tuser/tdata/tstrb; pkt_count=100.

Source files
------------

// File: rtl/axis_to_fifo.sv
// axis_to_fifo: write-side packer for the pcap-replay FIFO path.
// Each packet is written as one header word holding TUSER, followed by the
// data beats with a strobe bit interleaved after every byte. A packet ends on
// the first word whose strobes are not all ones. If the last beat has all
// strobes set, an all-zero terminator word is written after it.
//
// Ports:
//   axi_aclk, axi_aresetn   clock, asynchronous active-low reset
//   sw_rst                  synchronous soft reset (active high)
//   s_axis_*                AXI4-Stream slave (tdata/tstrb/tuser/tvalid/tready/tlast)
//   fifo_wr_en, fifo_din    FIFO write port (combinational, zero latency)
//   fifo_full               FIFO full; blocks all writes
//   pkt_count               packets fully written, wraps
//   err_count               malformed beats (short strobe without tlast), saturates
module axis_to_fifo #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_aresetn,
    input  logic                                 sw_rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic                                 fifo_wr_en,
    output logic [C_S_AXIS_DATA_WIDTH*9/8-1:0]   fifo_din,
    input  logic                                 fifo_full,
    output logic [31:0]                          pkt_count,
    output logic [15:0]                          err_count
);

    localparam int unsigned DW              = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned SW              = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned FIFO_DATA_WIDTH = C_S_AXIS_DATA_WIDTH * 9 / 8;
    localparam logic [SW-1:0] STRB_ONES     = '1;
    localparam logic [15:0]   ERR_MAX       = 16'hFFFF;

    typedef enum logic [1:0] {
        WR_HDR  = 2'd0,
        WR_PKT  = 2'd1,
        WR_TERM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_run;
    logic   w_full_strb;
    logic   w_pkt_inc;
    logic   w_err_inc;

    // Interleave one strobe bit above each data byte.
    function automatic logic [FIFO_DATA_WIDTH-1:0] pack_word(
        input logic [DW-1:0] data,
        input logic [SW-1:0] strb
    );
        logic [FIFO_DATA_WIDTH-1:0] word;
        word = '0;
        for (int i = 0; i < int'(SW); i++) begin
            word[9*i +: 8] = data[8*i +: 8];
            word[9*i + 8]  = strb[i];
        end
        return word;
    endfunction

    // Both resets gate the write strobe and ready immediately.
    assign w_run       = axi_aresetn & ~sw_rst;
    assign w_full_strb = (s_axis_tstrb == STRB_ONES);

    // Next-state and combinational write-port outputs.
    always_comb begin
        w_state_nxt   = r_state;
        fifo_wr_en    = 1'b0;
        s_axis_tready = 1'b0;
        fifo_din      = '0;
        w_pkt_inc     = 1'b0;
        w_err_inc     = 1'b0;
        if (w_run) begin
            case (r_state)
                WR_HDR: begin
                    // Header is written without consuming the beat.
                    if (s_axis_tvalid && !fifo_full) begin
                        fifo_wr_en  = 1'b1;
                        fifo_din    = pack_word(DW'(s_axis_tuser), STRB_ONES);
                        w_state_nxt = WR_PKT;
                    end
                end
                WR_PKT: begin
                    s_axis_tready = ~fifo_full;
                    if (s_axis_tvalid && !fifo_full) begin
                        fifo_wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            fifo_din = pack_word(s_axis_tdata, s_axis_tstrb);
                            if (w_full_strb) begin
                                w_state_nxt = WR_TERM;
                            end else begin
                                w_pkt_inc   = 1'b1;
                                w_state_nxt = WR_HDR;
                            end
                        end else if (!w_full_strb) begin
                            // Short strobe mid-packet would end it early at the reader.
                            fifo_din  = pack_word(s_axis_tdata, STRB_ONES);
                            w_err_inc = 1'b1;
                        end else begin
                            fifo_din = pack_word(s_axis_tdata, s_axis_tstrb);
                        end
                    end
                end
                WR_TERM: begin
                    if (!fifo_full) begin
                        fifo_wr_en  = 1'b1;
                        w_pkt_inc   = 1'b1;
                        w_state_nxt = WR_HDR;
                    end
                end
                default: begin
                    w_state_nxt = WR_HDR;
                end
            endcase
        end
    end

    // State and counters.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state   <= WR_HDR;
            pkt_count <= 32'd0;
            err_count <= 16'd0;
        end else if (sw_rst) begin
            r_state   <= WR_HDR;
            pkt_count <= 32'd0;
            err_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pkt_inc) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (w_err_inc && (err_count != ERR_MAX)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
